// File: rtl/pairing_job_arbiter_pkg.sv
// Shared widths and state encoding for the pairing-core job arbiter.
// WIDTH/W6 follow the tate_pairing core's field sizes.
package pairing_job_arbiter_pkg;

    localparam int WIDTH = 193;
    localparam int W6    = 1163;
    localparam int OP_W  = WIDTH + 1;
    localparam int RES_W = W6 + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/pairing_job_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping, returned both one-hot and as an index.
module pairing_job_arbiter_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx,
    output logic             found
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        // k runs 1..N_REQ so the current owner is considered last
        for (int k = 1; k <= N_REQ; k++) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/pairing_job_arbiter.sv
// Shares one tate_pairing core between N_REQ requesters: round-robin grant,
// operand latch, core reset sequencing, watchdog and a valid/ready response.
module pairing_job_arbiter
    import pairing_job_arbiter_pkg::*;
#(
    parameter int              N_REQ      = 4,
    parameter int              IDW        = 2,
    parameter int              RST_CYCLES = 2,
    parameter int              TO_W       = 20,
    parameter logic [TO_W-1:0] TIMEOUT    = 20'hFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*OP_W-1:0] x1_in,
    input  logic [N_REQ*OP_W-1:0] y1_in,
    input  logic [N_REQ*OP_W-1:0] x2_in,
    input  logic [N_REQ*OP_W-1:0] y2_in,
    output logic [N_REQ-1:0]      gnt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [RES_W-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  core_reset,
    output logic [OP_W-1:0]       core_x1,
    output logic [OP_W-1:0]       core_y1,
    output logic [OP_W-1:0]       core_x2,
    output logic [OP_W-1:0]       core_y2,
    input  logic                  core_done,
    input  logic [RES_W-1:0]      core_out
);

    localparam int LCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [LCW-1:0]   load_cnt;
    logic [TO_W-1:0]  wdog;
    logic [TO_W-1:0]  wdog_inc;

    logic [N_REQ-1:0] win_gnt;
    logic [IDW-1:0]   win_idx;
    logic             win_any;
    logic [OP_W-1:0]  sel_x1, sel_y1, sel_x2, sel_y2;

    pairing_job_arbiter_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (win_gnt),
        .idx   (win_idx),
        .found (win_any)
    );

    always_comb begin
        sel_x1 = '0;
        sel_y1 = '0;
        sel_x2 = '0;
        sel_y2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_x1 = x1_in[i*OP_W +: OP_W];
                sel_y1 = y1_in[i*OP_W +: OP_W];
                sel_x2 = x2_in[i*OP_W +: OP_W];
                sel_y2 = y2_in[i*OP_W +: OP_W];
            end
        end
    end

    // Watchdog counts completed RUN cycles; abort once TIMEOUT have elapsed
    assign wdog_inc = wdog + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            core_reset <= 1'b1;
            core_x1    <= '0;
            core_y1    <= '0;
            core_x2    <= '0;
            core_y2    <= '0;
            ptr        <= IDW'(N_REQ - 1);
            load_cnt   <= '0;
            wdog       <= '0;
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        core_x1  <= sel_x1;
                        core_y1  <= sel_y1;
                        core_x2  <= sel_x2;
                        core_y2  <= sel_y2;
                        gnt      <= win_gnt;
                        ptr      <= win_idx;
                        rsp_id   <= win_idx;
                        load_cnt <= LCW'(RST_CYCLES - 1);
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_cnt == '0) begin
                        wdog       <= '0;
                        core_reset <= 1'b0;
                        state      <= ST_RUN;
                    end else begin
                        load_cnt <= load_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    wdog <= wdog_inc;
                    // done takes priority over a simultaneous timeout
                    if (core_done) begin
                        rsp_data   <= core_out;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= ST_RESP;
                    end else if (wdog_inc == TIMEOUT) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
